// File: rtl/up_sample_reader.sv
// rtl/up_sample_reader.sv - 2x pixel-replication upsampler fed from a FIFO read port
//
// Pops one pixel at a time from the upstream FIFO (empty/rd_en/valid/din), stores
// the row in a line buffer and emits every pixel twice horizontally. The row is then
// replayed from the line buffer, so each input row also appears twice vertically.
//
// Ports:
//   clk, rst     single rising-edge clock, synchronous active-high reset
//   empty        FIFO empty flag
//   rd_en        FIFO pop request
//   valid, din   FIFO read data, one cycle after an accepted rd_en
//   dout         upsampled pixel
//   valid_out    dout valid, held stable with dout until ready
//   ready        downstream accept
//   frame_done   one-cycle pulse after the last pixel of a frame is accepted
//   overrun      sticky flag: FIFO data seen with no read outstanding
module up_sample_reader #(
  parameter int IN_WIDTH  = 320,
  parameter int IN_HEIGHT = 240,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              empty,
  input  logic              valid,
  input  logic [DATA_W-1:0] din,
  output logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid_out,
  input  logic              ready,
  output logic              frame_done,
  output logic              overrun
);

  localparam int LB_AW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int ROW_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(IN_HEIGHT - 1);

  typedef enum logic {S_FILL, S_REPEAT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] col;
  logic [ROW_W-1:0]  row;
  logic              pend;
  logic              hold_phase;
  logic [DATA_W-1:0] linebuf [IN_WIDTH];

  logic              accept;
  logic              ph1_acc;
  logic              last_col;
  logic              hold_free;
  logic              row_end;
  logic              fill_load;
  logic              rep_load;
  logic [LB_AW-1:0]  rep_addr;

  // dout/valid_out are the hold register itself.
  assign accept    = valid_out & ready;
  assign ph1_acc   = accept & hold_phase;
  assign last_col  = (col == LAST_COL);
  assign hold_free = !valid_out | ph1_acc;
  // Final pixel of the current row pass is leaving: nothing more to fetch this pass.
  assign row_end   = ph1_acc & last_col;

  // The row end guard stops a read of a non-existent column W during FILL->REPEAT.
  assign rd_en     = (state == S_FILL) & !empty & !pend & hold_free & !row_end;
  assign fill_load = valid & pend;

  // Replay address: the column after the pixel that is leaving, else the current one.
  assign rep_addr  = ph1_acc ? LB_AW'(col + ADDR_W'(1)) : col[LB_AW-1:0];
  assign rep_load  = (state == S_REPEAT) & hold_free & !row_end;

  always_ff @(posedge clk) begin
    if (!rst && fill_load) begin
      linebuf[col[LB_AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FILL;
      col        <= '0;
      row        <= '0;
      pend       <= 1'b0;
      hold_phase <= 1'b0;
      valid_out  <= 1'b0;
      dout       <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (rd_en) begin
        pend <= 1'b1;
      end

      // Drain the hold register: phase 0 -> phase 1 -> empty.
      if (accept) begin
        if (!hold_phase) begin
          hold_phase <= 1'b1;
        end else begin
          valid_out <= 1'b0;
        end
      end

      if (ph1_acc) begin
        if (last_col) begin
          col <= '0;
          if (state == S_FILL) begin
            state <= S_REPEAT;
          end else begin
            state <= S_FILL;
            if (row == LAST_ROW) begin
              row        <= '0;
              frame_done <= 1'b1;
            end else begin
              row <= row + ROW_W'(1);
            end
          end
        end else begin
          col <= col + ADDR_W'(1);
        end
      end

      // Reads are only issued when the hold register frees up the following
      // cycle, so returning data always lands in an empty hold register.
      if (valid) begin
        if (pend) begin
          pend       <= 1'b0;
          dout       <= din;
          valid_out  <= 1'b1;
          hold_phase <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end

      // The line buffer read registers straight into the hold register, which
      // keeps REPEAT at one output per cycle.
      if (rep_load) begin
        dout       <= linebuf[rep_addr];
        valid_out  <= 1'b1;
        hold_phase <= 1'b0;
      end
    end
  end

endmodule
